// File: rtl/riscv_keypad_scanner_pkg.sv
// rtl/riscv_keypad_scanner_pkg.sv - shared types, constants and column decoder for the keypad scanner
package riscv_keypad_scanner_pkg;

    localparam int KP_ROWS             = 4;
    localparam int KP_COLS             = 4;
    localparam int KP_CLK_DIV_DEFAULT  = 100000;
    localparam int KP_DEBOUNCE_DEFAULT = 10;

    typedef enum logic [1:0] {
        KP_SCAN     = 2'd0,
        KP_DEBOUNCE = 2'd1,
        KP_PRESSED  = 2'd2
    } kp_state_e;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } kp_col_t;

    // Valid only when exactly one column line is pulled low.
    function automatic kp_col_t kp_decode_cols(input logic [KP_COLS-1:0] cols);
        kp_col_t r;
        r.valid = 1'b1;
        r.idx   = 2'd0;
        case (cols)
            4'b1110: r.idx = 2'd0;
            4'b1101: r.idx = 2'd1;
            4'b1011: r.idx = 2'd2;
            4'b0111: r.idx = 2'd3;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/riscv_tick_gen.sv
// rtl/riscv_tick_gen.sv - free-running divider emitting a one-cycle tick every DIV clocks
module riscv_tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/riscv_keypad_scanner.sv
// rtl/riscv_keypad_scanner.sv - 4x4 matrix keypad scanner with debounce and key code encoding
module riscv_keypad_scanner
    import riscv_keypad_scanner_pkg::*;
#(
    parameter int CLK_DIV        = KP_CLK_DIV_DEFAULT,
    parameter int DEBOUNCE_TICKS = KP_DEBOUNCE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] row_out,
    input  logic [3:0] col_in,
    output logic [3:0] keyboard,
    output logic       key_valid,
    output logic       key_strobe
);

    localparam int               DEB_W    = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_TICKS);

    logic               tick;
    logic [KP_COLS-1:0] col_meta_q;
    logic [KP_COLS-1:0] col_s_q;

    kp_state_e          state_q, state_d;
    logic [1:0]         row_idx_q, row_idx_d;
    logic [KP_ROWS-1:0] row_out_q, row_out_d;
    logic [3:0]         cand_q, cand_d;
    logic [3:0]         keyboard_q, keyboard_d;
    logic               valid_q, valid_d;
    logic               strobe_q, strobe_d;
    logic [DEB_W-1:0]   deb_q, deb_d;
    logic [DEB_W-1:0]   rel_q, rel_d;

    kp_col_t            dec;
    logic [3:0]         code;

    riscv_tick_gen #(.DIV(CLK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        dec        = kp_decode_cols(col_s_q);
        code       = {row_idx_q, dec.idx};
        state_d    = state_q;
        row_idx_d  = row_idx_q;
        cand_d     = cand_q;
        keyboard_d = keyboard_q;
        valid_d    = valid_q;
        strobe_d   = 1'b0;
        deb_d      = deb_q;
        rel_d      = rel_q;
        if (tick) begin
            unique case (state_q)
                KP_SCAN: begin
                    if (dec.valid) begin
                        cand_d = code;
                        if (DEB_LAST == DEB_W'(1)) begin
                            state_d    = KP_PRESSED;
                            keyboard_d = code;
                            valid_d    = 1'b1;
                            strobe_d   = 1'b1;
                            deb_d      = '0;
                        end else begin
                            state_d = KP_DEBOUNCE;
                            deb_d   = DEB_W'(1);
                        end
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end
                KP_DEBOUNCE: begin
                    // Row stays frozen here so a bounce re-scans the same row next tick.
                    if (dec.valid && code == cand_q) begin
                        if (deb_q + DEB_W'(1) == DEB_LAST) begin
                            state_d    = KP_PRESSED;
                            keyboard_d = cand_q;
                            valid_d    = 1'b1;
                            strobe_d   = 1'b1;
                            deb_d      = '0;
                        end else begin
                            deb_d = deb_q + DEB_W'(1);
                        end
                    end else begin
                        state_d = KP_SCAN;
                        deb_d   = '0;
                    end
                end
                KP_PRESSED: begin
                    if (col_s_q == '1) begin
                        if (rel_q + DEB_W'(1) == DEB_LAST) begin
                            state_d   = KP_SCAN;
                            valid_d   = 1'b0;
                            rel_d     = '0;
                            row_idx_d = row_idx_q + 2'd1;
                        end else begin
                            rel_d = rel_q + DEB_W'(1);
                        end
                    end else begin
                        rel_d = '0;
                    end
                end
                default: state_d = KP_SCAN;
            endcase
        end
        row_out_d = ~(KP_ROWS'(1) << row_idx_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_meta_q <= '1;
            col_s_q    <= '1;
            state_q    <= KP_SCAN;
            row_idx_q  <= 2'd0;
            row_out_q  <= 4'b1110;
            cand_q     <= 4'h0;
            keyboard_q <= 4'h0;
            valid_q    <= 1'b0;
            strobe_q   <= 1'b0;
            deb_q      <= '0;
            rel_q      <= '0;
        end else begin
            col_meta_q <= col_in;
            col_s_q    <= col_meta_q;
            state_q    <= state_d;
            row_idx_q  <= row_idx_d;
            row_out_q  <= row_out_d;
            cand_q     <= cand_d;
            keyboard_q <= keyboard_d;
            valid_q    <= valid_d;
            strobe_q   <= strobe_d;
            deb_q      <= deb_d;
            rel_q      <= rel_d;
        end
    end

    assign row_out    = row_out_q;
    assign keyboard   = keyboard_q;
    assign key_valid  = valid_q;
    assign key_strobe = strobe_q;

endmodule

// File: doc/riscv_keypad_scanner.md
Name: riscv_keypad_scanner

Overview:
- Scans the board's 4x4 matrix keypad, debounces presses, and encodes the held key as a 4-bit code.
- Drives the `keyboard[3:0]` input of the IO bridge directly.
- CPU reads the code at IO address 0xfffffc08 as {24'h0, keyboard}.
- Sits between the board pins and the IO bridge. Runs on the CPU clock domain.

Parameters:
- CLK_DIV, 100000, clk cycles per scan tick (1 ms at 100 MHz); must be >= 2.
- DEBOUNCE_TICKS, 10, consecutive identical tick samples required to accept a press or a release; must be >= 1.

Ports:
- clk  input  1  CPU clock.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- row_out  output  4  keypad row drive, active-low one-hot.
- col_in  input  4  keypad column sense, active-low, pulled up externally; asynchronous to clk.
- keyboard  output  4  last accepted key code; holds after release.
- key_valid  output  1  high while the accepted key is still held (debounced).
- key_strobe  output  1  one-cycle pulse when a new press is accepted.

Behaviour:
- Reset (rst=0, async): row_out=4'b1110, keyboard=4'h0, key_valid=0, key_strobe=0, state=SCAN, all counters 0, col synchroniser flops=4'b1111.
- col_in passes through a 2-flop synchroniser; only the synchronised value (col_s) is used.
- Tick counter:
  - Counts 0..CLK_DIV-1 and wraps.
  - tick=1 for the single cycle in which the count equals CLK_DIV-1.
  - All FSM decisions happen only on tick cycles. The row is therefore held a full tick period before sampling.
- row_idx (2 bits) selects the driven row; row_out = ~(4'b0001 << row_idx).
- Valid sample: exactly one bit of col_s is 0. col_idx = position of that 0 bit.
- Code = {row_idx, col_idx}, i.e. row*4+col.
- FSM, sampled on tick:
  - SCAN, sample all 1s, or more than one 0 (multi-key): row_idx increments mod 4 (3 -> 0 wrap). Stay in SCAN.
  - SCAN, valid sample: capture cand_code; deb_cnt=1; row frozen.
    - If DEBOUNCE_TICKS==1, go directly to PRESSED (accept actions below).
    - Otherwise go to DEBOUNCE.
  - DEBOUNCE, sample encodes cand_code: deb_cnt++.
    - When deb_cnt reaches DEBOUNCE_TICKS, go to PRESSED.
    - On entry to PRESSED: keyboard<=cand_code, key_valid<=1, key_strobe<=1 for that one cycle.
  - DEBOUNCE, any other sample (release, bounce, different or extra column): go to SCAN, deb_cnt=0. row_idx does not advance on this tick. keyboard is unchanged.
  - PRESSED, sample all 1s: rel_cnt++. When rel_cnt reaches DEBOUNCE_TICKS: key_valid<=0, go to SCAN, rel_cnt=0, row_idx advances.
  - PRESSED, any sample with a 0: rel_cnt=0. A second key pressed while one is held is ignored; no new strobe.
- Latency: a clean press is accepted DEBOUNCE_TICKS ticks after the first valid tick sample, plus 2 cycles of synchroniser delay.
- key_strobe is never high for two consecutive cycles. It asserts only on the SCAN/DEBOUNCE -> PRESSED transition.
- Reset asserted mid-debounce or mid-press: immediate return to reset values; no strobe is produced.
- keyboard code 0 is a legal key; software distinguishes it from "no key" via key_valid/key_strobe, which the bridge exposes in a later revision.

Decomposition:
- riscv_defs.v gains:
  - `KP_SCAN`, `KP_DEBOUNCE`, `KP_PRESSED` (2-bit state encodings).
  - `KP_ROWS`=4, `KP_COLS`=4.
  - `KP_CLK_DIV_DEFAULT`, `KP_DEBOUNCE_DEFAULT`.
- One sub-module: riscv_tick_gen (parameter DIV; ports clk, rst, tick). It is reusable for future timer IO.
- Synchroniser and FSM stay inline.

Test Plan (CLK_DIV=4, DEBOUNCE_TICKS=3, keypad model drives col_in from row_out):
- Reset: hold rst=0 with col_in=4'b0000 -> row_out=4'b1110, keyboard=0, key_valid=0, key_strobe=0; release rst -> row_out rotates 1110,1101,1011,0111,1110 every 4 cycles.
- Clean press of key row 2/col 1: within 3 ticks of first valid sample, keyboard=4'h9, key_valid=1, one-cycle key_strobe; release -> key_valid=0 after 3 all-high ticks; keyboard stays 4'h9.
- Bounce: key row 1/col 3 present for 2 ticks then gone -> no strobe, keyboard unchanged, FSM back to SCAN and rotation resumes.
- Multi-key: row 0 cols 0 and 2 pressed together -> no strobe; scanning continues past row 0.
- Second key while held: hold key 4'h5 (accepted), then also press 4'hA -> no second strobe, keyboard stays 4'h5; release both -> key_valid drops after 3 ticks; pressing 4'hA alone then yields keyboard=4'hA with a strobe.
- Reset mid-operation: assert rst during DEBOUNCE of key 4'hF -> outputs at reset values immediately; no strobe after rst deasserts until a fresh 3-tick debounce completes.
